// File: rtl/csa_stream_accumulator_if.sv
// Stream handshake bundle for csa_stream_accumulator: operand beats in, packet totals out.
// The master side produces operands and consumes results; the slave side is the accumulator.
interface csa_stream_accumulator_if #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [15:0]      out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_count
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand accumulator: beats fold into a carry-save S/C pair with no carry
// propagation; one resolve cycle per packet turns the redundant pair into a binary total.
module csa_stream_accumulator #(
  parameter int WIDTH  = 32,
  parameter int GUARD  = 8,
  parameter int SIGNED = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  csa_stream_accumulator_if.slave  bus
);
  localparam int ACC_W = WIDTH + GUARD;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [ACC_W-1:0] r_q, r_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;
  logic [15:0]      out_count_q, out_count_d;

  logic             in_ready_s;
  logic             beat_acc_s;
  logic [ACC_W-1:0] x_s;

  function automatic logic [ACC_W-1:0] ext_operand(input logic [WIDTH-1:0] d);
    if (SIGNED != 0) begin
      return {{GUARD{d[WIDTH-1]}}, d};
    end else begin
      return {{GUARD{1'b0}}, d};
    end
  endfunction

  function automatic logic [ACC_W-1:0] csa_carry(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b,
                                                 input logic [ACC_W-1:0] x);
    logic [ACC_W-1:0] maj;
    maj = (a & b) | (a & x) | (b & x);
    return {maj[ACC_W-2:0], 1'b0};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Signed totals must sign-extend from bit WIDTH-1; unsigned totals must have empty guard bits.
  function automatic logic ovf_detect(input logic [ACC_W-1:0] r);
    logic [GUARD:0] hi;
    hi = r[ACC_W-1:WIDTH-1];
    if (SIGNED != 0) begin
      return !((&hi) || !(|hi));
    end else begin
      return |hi[GUARD:1];
    end
  endfunction

  assign in_ready_s = (state_q == ST_ACCUM) && !rst;
  assign beat_acc_s = bus.in_valid && in_ready_s;
  assign x_s        = ext_operand(bus.in_data);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_count = out_count_q;

  // Next-state and datapath updates for the accumulate / resolve / present sequence.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;
    case (state_q)
      ST_ACCUM: begin
        if (beat_acc_s) begin
          s_d   = s_q ^ c_q ^ x_s;
          c_d   = csa_carry(s_q, c_q, x_s);
          cnt_d = sat_inc(cnt_q);
          if (bus.in_last) begin
            state_d = ST_RESOLVE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_RESOLVE: begin
        r_d         = s_q + c_q;
        out_count_d = cnt_q;
        state_d     = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        // First OUTPUT cycle loads the result registers; afterwards they hold until accepted.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_sum_d   = r_q;
          out_ovf_d   = ovf_detect(r_q);
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          s_d         = {ACC_W{1'b0}};
          c_d         = {ACC_W{1'b0}};
          cnt_d       = 16'd0;
          state_d     = ST_ACCUM;
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      default: begin
        state_d     = ST_ACCUM;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial packet or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      s_q         <= {ACC_W{1'b0}};
      c_q         <= {ACC_W{1'b0}};
      cnt_q       <= 16'd0;
      r_q         <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
      out_sum_q   <= {ACC_W{1'b0}};
      out_ovf_q   <= 1'b0;
      out_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Scoreboard bench for csa_stream_accumulator: a signed and an unsigned instance share one
// stimulus driver; expected totals come from a plain binary-addition model.
module tb_csa_stream_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_stream_accumulator_if #(.WIDTH(32), .ACC_W(40)) ifs ();
  csa_stream_accumulator_if #(.WIDTH(32), .ACC_W(40)) ifu ();

  csa_stream_accumulator #(.WIDTH(32), .GUARD(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .bus(ifs)
  );
  csa_stream_accumulator #(.WIDTH(32), .GUARD(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .bus(ifu)
  );

  logic        sel  = 1'b0;   // 0: signed instance, 1: unsigned instance
  logic        v    = 1'b0;
  logic        last = 1'b0;
  logic [31:0] data = 32'd0;
  logic        ordy = 1'b1;

  assign ifs.in_valid  = v & ~sel;
  assign ifu.in_valid  = v & sel;
  assign ifs.in_data   = data;
  assign ifu.in_data   = data;
  assign ifs.in_last   = last;
  assign ifu.in_last   = last;
  assign ifs.out_ready = ordy & ~sel;
  assign ifu.out_ready = ordy & sel;

  logic        m_in_ready, m_out_valid, m_ovf;
  logic [39:0] m_sum;
  logic [15:0] m_count;
  assign m_in_ready  = sel ? ifu.in_ready  : ifs.in_ready;
  assign m_out_valid = sel ? ifu.out_valid : ifs.out_valid;
  assign m_sum       = sel ? ifu.out_sum   : ifs.out_sum;
  assign m_ovf       = sel ? ifu.out_ovf   : ifs.out_ovf;
  assign m_count     = sel ? ifu.out_count : ifs.out_count;

  typedef struct {
    logic [39:0] sum;
    logic        ovf;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [39:0] model_acc = 40'd0;
  int          model_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic model_ovf(input logic [39:0] t, input logic is_uns);
    if (is_uns) return (t > 40'h00FFFFFFFF);
    return ($signed(t) > 40'sd2147483647) || ($signed(t) < -40'sd2147483648);
  endfunction

  task automatic model_reset();
    model_acc = 40'd0;
    model_cnt = 0;
  endtask

  // Drive one beat and hold it until the DUT accepts it on a rising edge.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    exp_t e;
    @(negedge clk);
    data = d; last = l; v = 1'b1;
    n = 0;
    while (!m_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    model_acc = model_acc + (sel ? {8'd0, d} : {{8{d[31]}}, d});
    model_cnt++;
    if (l) begin
      e.sum = model_acc;
      e.ovf = model_ovf(model_acc, sel);
      e.cnt = (model_cnt > 65535) ? 16'hFFFF : 16'(model_cnt);
      exp_q.push_back(e);
      model_reset();
    end
  endtask

  task automatic idle();
    @(negedge clk);
    v = 1'b0; last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Result monitor: compares each handshaken result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && m_out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 64'd1, 64'd0);
      end else if (ordy) begin
        chk("out_sum",   64'(m_sum),   64'(exp_q[0].sum));
        chk("out_ovf",   64'(m_ovf),   64'(exp_q[0].ovf));
        chk("out_count", 64'(m_count), 64'(exp_q[0].cnt));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] hold_sum;
    logic [15:0] hold_cnt;
    int n;

    // Reset state
    #12;
    chk("rst_in_ready",  64'(m_in_ready),  64'd0);
    chk("rst_out_valid", 64'(m_out_valid), 64'd0);
    chk("rst_out_sum",   64'(m_sum),       64'd0);
    chk("rst_out_ovf",   64'(m_ovf),       64'd0);
    chk("rst_out_count", 64'(m_count),     64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(m_in_ready), 64'd1);

    // 1..10 back-to-back with latency check
    for (int i = 1; i <= 10; i++) send_beat(32'(i), (i == 10));
    @(negedge clk); v = 1'b0; last = 1'b0;
    chk("lat_edge_t",  64'(m_out_valid), 64'd0);
    chk("lat_ready0",  64'(m_in_ready),  64'd0);
    @(negedge clk);
    chk("lat_edge_t1", 64'(m_out_valid), 64'd0);
    @(negedge clk);
    chk("lat_edge_t2", 64'(m_out_valid), 64'd1);
    drain();

    // Signed cases
    send_beat(32'hFFFFFFF6, 1'b0); send_beat(32'hFFFFFFFB, 1'b1); idle(); drain();
    send_beat(32'hFFFFFFFF, 1'b0); send_beat(32'h00000001, 1'b1); idle(); drain();
    send_beat(32'h7FFFFFFF, 1'b0); send_beat(32'h7FFFFFFF, 1'b1); idle(); drain();
    send_beat(32'h80000000, 1'b0); send_beat(32'hFFFFFFFF, 1'b1); idle(); drain();
    send_beat(32'h12345678, 1'b1); idle(); drain();

    // Unsigned instance
    sel = 1'b1;
    @(negedge clk);
    send_beat(32'hFFFFFFFF, 1'b0); send_beat(32'hFFFFFFFF, 1'b1); idle(); drain();
    send_beat(32'hFFFFFFF6, 1'b0); send_beat(32'h00000009, 1'b1); idle(); drain();
    sel = 1'b0;
    @(negedge clk);

    // Backpressure: result held while a beat of 7 waits at the input
    @(posedge clk); #1 ordy = 1'b0;
    send_beat(32'd2, 1'b0); send_beat(32'd3, 1'b1);
    @(negedge clk);
    data = 32'd7; last = 1'b1; v = 1'b1;
    n = 0;
    while (!m_out_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_valid_rise", 64'(m_out_valid), 64'd1);
    hold_sum = m_sum;
    hold_cnt = m_count;
    chk("bp_sum",   64'(hold_sum), 64'(exp_q[0].sum));
    chk("bp_count", 64'(hold_cnt), 64'(exp_q[0].cnt));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(m_out_valid), 64'd1);
      chk("bp_hold_sum",   64'(m_sum),       64'(hold_sum));
      chk("bp_hold_count", 64'(m_count),     64'(hold_cnt));
      chk("bp_in_ready",   64'(m_in_ready),  64'd0);
    end
    @(posedge clk); #1 ordy = 1'b1;
    send_beat(32'd7, 1'b1); idle(); drain();

    // Reset mid-packet discards the partial sum
    send_beat(32'd3, 1'b0); send_beat(32'd4, 1'b0); send_beat(32'd5, 1'b0);
    @(negedge clk);
    v = 1'b0; rst = 1'b1;
    #1 chk("midrst_in_ready", 64'(m_in_ready), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", 64'(m_out_valid), 64'd0);
    end
    send_beat(32'd4, 1'b0); send_beat(32'd5, 1'b1); idle(); drain();

    // Count saturation
    for (int i = 0; i < 70000; i++) send_beat(32'd0, 1'b0);
    send_beat(32'd1, 1'b1); idle(); drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
